count_window_ctrl: RTL
======================

// Module: count_window_ctrl
//
// PURPOSE
//  Sequences an N-bit event counter over a programmable time window: arm, count for
//  win_len cycles (or until stop), then present the result on a valid/ready handshake.
//  Sits between the local control logic and the event-counter datapath.
//  The event input is a qualified strobe in the clk domain, not a derived clock.
//
// PARAMETERS
//  N   8   event counter width (count, ovf semantics)
//  W   16  window-length width (win_len, internal window timer)
//
// PORTS
//  clk        in   1   single system clock, all logic on posedge
//  rstn       in   1   asynchronous, active-low reset
//  start      in   1   pulse: begin a measurement (honoured in IDLE only)
//  stop       in   1   pulse: abort window early, keep partial count
//  win_len    in   W   window length in cycles, sampled on accepted start
//  ev_in      in   1   event strobe, one event per high cycle
//  busy       out  1   high in ARM and COUNT
//  cnt_valid  out  1   result available (HOLD)
//  cnt_ready  in   1   consumer accepts result
//  count      out  N   measured event count, stable while cnt_valid
//  ovf        out  1   counter passed 2^N-1 during the window, stable while cnt_valid
//
// BEHAVIOUR
//  - Reset (rstn=0, async): state=IDLE; busy=0, cnt_valid=0, count=0, ovf=0, timer=0.
//  - FSM IDLE -> ARM -> COUNT -> HOLD -> IDLE; all outputs registered.
//  - IDLE: start=1 -> ARM, latch win_len. stop ignored; start&stop same cycle = start.
//  - ARM (1 cycle): clear count/ovf, load timer=latched win_len; ev_in ignored.
//    Next: HOLD if stop=1 or win_len==0, else COUNT.
//  - COUNT: each cycle count+=ev_in, timer-=1. After exactly win_len COUNT cycles -> HOLD.
//    Event in the last COUNT cycle is counted. stop=1 -> HOLD next cycle; ev_in in the
//    stop cycle IS counted.
//  - HOLD: cnt_valid=1; count/ovf frozen. cnt_valid&cnt_ready -> IDLE next cycle,
//    cnt_valid drops. start in HOLD (incl. handshake cycle) ignored; no queuing.
//  - Latency: start at t -> busy from t+1; COUNT t+2..t+1+win_len; cnt_valid at t+2+win_len.
//  - Overflow: increment at count==2^N-1 sets ovf=1 (sticky until next ARM).
//  - win_len/start changes outside IDLE have no effect. Reset mid-window aborts, no result.
//
// CONFIGURATION
//  COUNT_WINDOW_SAT_EN
//   defined:   count saturates at 2^N-1; further events leave it at all-ones, ovf=1.
//   undefined: count wraps modulo 2^N; ovf=1 marks that at least one wrap occurred.
//
// STRUCTURE
//  - Package count_window_pkg: state typedef (IDLE, ARM, COUNT, HOLD, 2-bit encoding),
//    state localparams, default N/W constants.
//  - One sub-module: count_window_core -- N-bit counter with clr, inc, ovf flag,
//    saturate/wrap selection; FSM and window timer stay in count_window_ctrl.
//
// TESTING
//  1. N=8, win_len=10, ev_in=1 every cycle, start@t -> cnt_valid@t+12, count=10, ovf=0.
//  2. win_len=0, start -> ARM then HOLD, count=0, cnt_valid 2 cycles after start.
//  3. win_len=100, ev_in=1, stop at 5th COUNT cycle -> count=5, cnt_valid next cycle.
//  4. win_len=300, ev_in=1 always -> wrap build: count=44, ovf=1; SAT_EN: count=255, ovf=1.
//  5. cnt_ready=0 for 20 cycles in HOLD, pulse start -> count stable, start ignored;
//     cnt_ready=1 -> IDLE next cycle; subsequent start accepted.
//  6. rstn low mid-COUNT -> all outputs 0 immediately; new start after release runs clean.

Source files
------------

// File: rtl/count_window_pkg.sv
// -----------------------------------------------------------------------------
// count_window_pkg
// Shared definitions for the count-window controller:
//   - cw_state_e   : controller state type (IDLE, ARM, COUNT, HOLD), 2-bit encoding
//   - *_ENC        : state encodings as plain localparams
//   - CW_N_DEFAULT : default event-counter width
//   - CW_W_DEFAULT : default window-length width
// Build option: COUNT_WINDOW_SAT_EN (used by count_window_core) selects a
// saturating counter instead of a wrapping one.
// -----------------------------------------------------------------------------
package count_window_pkg;

    localparam int CW_N_DEFAULT = 8;
    localparam int CW_W_DEFAULT = 16;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] ARM_ENC   = 2'd1;
    localparam logic [1:0] COUNT_ENC = 2'd2;
    localparam logic [1:0] HOLD_ENC  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = IDLE_ENC,
        ARM   = ARM_ENC,
        COUNT = COUNT_ENC,
        HOLD  = HOLD_ENC
    } cw_state_e;

endpackage

// File: rtl/count_window_core.sv
// -----------------------------------------------------------------------------
// count_window_core
// N-bit event counter with synchronous clear and sticky overflow flag.
// Ports:
//   clk   in   system clock
//   rstn  in   asynchronous active-low reset
//   clr   in   clear count and ovf (has priority over inc)
//   inc   in   count one event this cycle
//   count out  N-bit event count (registered)
//   ovf   out  set when an increment happens at all-ones (sticky until clr)
// Build option COUNT_WINDOW_SAT_EN:
//   defined   -> count sticks at all-ones once reached
//   undefined -> count wraps modulo 2^N
// -----------------------------------------------------------------------------
module count_window_core
    import count_window_pkg::*;
#(
    parameter int N = CW_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [N-1:0] count,
    output logic         ovf
);

    logic [N-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            if (count_q == '1) begin
                ovf_d = 1'b1;
`ifdef COUNT_WINDOW_SAT_EN
                count_d = count_q;
`else
                count_d = '0;
`endif
            end else begin
                count_d = count_q + N'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/count_window_ctrl.sv
// -----------------------------------------------------------------------------
// count_window_ctrl
// Sequences an event counter over a programmable window:
// IDLE -> ARM -> COUNT (win_len cycles or until stop) -> HOLD (valid/ready).
// Ports:
//   clk        in   system clock
//   rstn       in   asynchronous active-low reset
//   start      in   begin a measurement (IDLE only)
//   stop       in   end the window early, keeping the partial count
//   win_len    in   window length in cycles, sampled on accepted start
//   ev_in      in   event strobe, one event per high cycle
//   busy       out  high in ARM and COUNT
//   cnt_valid  out  result available (HOLD)
//   cnt_ready  in   consumer accepts the result
//   count      out  measured event count
//   ovf        out  counter passed all-ones during the window
// Build option COUNT_WINDOW_SAT_EN selects saturate (defined) or wrap
// (undefined) counting inside count_window_core.
// -----------------------------------------------------------------------------
module count_window_ctrl
    import count_window_pkg::*;
#(
    parameter int N = CW_N_DEFAULT,
    parameter int W = CW_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] win_len,
    input  logic         ev_in,
    output logic         busy,
    output logic         cnt_valid,
    input  logic         cnt_ready,
    output logic [N-1:0] count,
    output logic         ovf
);

    cw_state_e    state_q, state_d;
    logic [W-1:0] win_len_q, win_len_d;
    logic [W-1:0] timer_q, timer_d;
    logic         busy_q, busy_d;
    logic         valid_q, valid_d;
    logic         core_clr;
    logic         core_inc;

    always_comb begin
        state_d   = state_q;
        win_len_d = win_len_q;
        timer_d   = timer_q;
        core_clr  = 1'b0;
        core_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ARM;
                    win_len_d = win_len;
                end
            end
            ARM: begin
                core_clr = 1'b1;
                timer_d  = win_len_q;
                if (stop || (win_len_q == '0)) begin
                    state_d = HOLD;
                end else begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                core_inc = ev_in;
                timer_d  = timer_q - W'(1);
                // timer holds the remaining COUNT cycles including this one,
                // so timer==1 marks the last cycle of the window.
                if (stop || (timer_q == W'(1))) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they come straight off flops.
        busy_d  = (state_d == ARM) || (state_d == COUNT);
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            win_len_q <= '0;
            timer_q   <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_len_q <= win_len_d;
            timer_q   <= timer_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    count_window_core #(
        .N(N)
    ) u_core (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (core_clr),
        .inc   (core_inc),
        .count (count),
        .ovf   (ovf)
    );

    assign busy      = busy_q;
    assign cnt_valid = valid_q;

endmodule
